hazard_unit_md: RTL and testbench

HAZARD_UNIT_MD -- requirements
Module: hazard_unit_md

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/md_stall_seq.sv | 75 +++++++
 rtl/hazard_unit_md.sv | 74 +++++++
 tb/tb_hazard_unit_md.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit and its M/D stall sequencer.
package hazard_pkg;

  // Width of the M/D latency down-counter; latencies are limited to 2..255.
  localparam int unsigned LAT_W = 8;

  // Operand source selects driven on ForwardAE/ForwardBE.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multi-cycle M/D sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Forward select from the two match conditions; the M-stage match wins.
  function automatic logic [1:0] fwd_sel(input logic match_m, input logic match_w);
    if (match_m) return FWD_MEM;
    if (match_w) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_stall_seq.sv
// M/D sequencer: holds the E stage for LAT cycles per op, then strobes done.
module md_stall_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 34
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic stall,
  output logic done
);

  if (MUL_LAT < 2 || MUL_LAT > 255) begin : g_bad_mul_lat
    $error("md_stall_seq: MUL_LAT must be within 2..255");
  end
  if (DIV_LAT < 2 || DIV_LAT > 255) begin : g_bad_div_lat
    $error("md_stall_seq: DIV_LAT must be within 2..255");
  end

  // The accepting IDLE cycle already stalls, so BUSY covers the remaining LAT-1.
  localparam logic [LAT_W-1:0] MUL_INIT = LAT_W'(MUL_LAT - 2);
  localparam logic [LAT_W-1:0] DIV_INIT = LAT_W'(DIV_LAT - 2);

  md_state_t        state_q, state_d;
  logic [LAT_W-1:0] cnt_q,   cnt_d;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and stall/done decode; outputs forced low while in reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = is_div ? DIV_INIT : MUL_INIT;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!rst_n) begin
      stall = 1'b0;
      done  = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_unit_md.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// multi-cycle M/D stall sequencing.
module hazard_unit_md
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              M_RegWrite,
  input  logic              W_RegWrite,
  input  logic              E_ResultSrc_0,
  input  logic              E_PCSrc,
  input  logic              E_MdOp,
  input  logic              E_MdIsDiv,
  input  logic [REG_AW-1:0] D_Rs1,
  input  logic [REG_AW-1:0] D_Rs2,
  input  logic [REG_AW-1:0] E_Rs1,
  input  logic [REG_AW-1:0] E_Rs2,
  input  logic [REG_AW-1:0] E_Rd,
  input  logic [REG_AW-1:0] M_Rd,
  input  logic [REG_AW-1:0] W_Rd,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              F_Stall,
  output logic              D_Stall,
  output logic              E_Stall,
  output logic              D_Flush,
  output logic              E_Flush,
  output logic              M_Flush,
  output logic              md_busy,
  output logic              md_done
);

  logic md_stall;
  logic md_done_w;
  logic lw_stall;

  md_stall_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (E_MdOp),
    .is_div (E_MdIsDiv),
    .stall  (md_stall),
    .done   (md_done_w)
  );

  // Operand forwarding; stays live through reset and M/D stalls.
  always_comb begin
    ForwardAE = fwd_sel(M_RegWrite && (E_Rs1 != '0) && (E_Rs1 == M_Rd),
                        W_RegWrite && (E_Rs1 != '0) && (E_Rs1 == W_Rd));
    ForwardBE = fwd_sel(M_RegWrite && (E_Rs2 != '0) && (E_Rs2 == M_Rd),
                        W_RegWrite && (E_Rs2 != '0) && (E_Rs2 == W_Rd));
  end

  // Stall/flush decode; the seq outputs are already reset-gated, the rest are gated here.
  always_comb begin
    lw_stall = E_ResultSrc_0 && (E_Rd != '0) && ((D_Rs1 == E_Rd) || (D_Rs2 == E_Rd));
    F_Stall  = rst_n && (lw_stall || md_stall);
    D_Stall  = rst_n && (lw_stall || md_stall);
    E_Stall  = md_stall;
    M_Flush  = md_stall;
    E_Flush  = rst_n && (lw_stall || E_PCSrc) && !md_stall;
    D_Flush  = rst_n && E_PCSrc && !md_stall;
    md_busy  = md_stall;
    md_done  = md_done_w;
  end

endmodule

// File: tb/tb_hazard_unit_md.sv
// Self-checking bench for hazard_unit_md: directed scenarios plus random traffic,
// every cycle compared against a cycle-count reference model.
module tb_hazard_unit_md;

  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              M_RegWrite, W_RegWrite, E_ResultSrc_0, E_PCSrc, E_MdOp, E_MdIsDiv;
  logic [REG_AW-1:0] D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, md_busy, md_done;

  hazard_unit_md #(
    .REG_AW  (REG_AW),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .M_RegWrite    (M_RegWrite),
    .W_RegWrite    (W_RegWrite),
    .E_ResultSrc_0 (E_ResultSrc_0),
    .E_PCSrc       (E_PCSrc),
    .E_MdOp        (E_MdOp),
    .E_MdIsDiv     (E_MdIsDiv),
    .D_Rs1         (D_Rs1),
    .D_Rs2         (D_Rs2),
    .E_Rs1         (E_Rs1),
    .E_Rs2         (E_Rs2),
    .E_Rd          (E_Rd),
    .M_Rd          (M_Rd),
    .W_Rd          (W_Rd),
    .ForwardAE     (ForwardAE),
    .ForwardBE     (ForwardBE),
    .F_Stall       (F_Stall),
    .D_Stall       (D_Stall),
    .E_Stall       (E_Stall),
    .D_Flush       (D_Flush),
    .E_Flush       (E_Flush),
    .M_Flush       (M_Flush),
    .md_busy       (md_busy),
    .md_done       (md_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stall cycles still owed by the current op, and a pending done strobe.
  int stall_left = 0;
  bit done_now   = 1'b0;

  // Outputs captured at the last sample point.
  logic [1:0] s_fa, s_fb;
  logic       s_fs, s_ds, s_es, s_df, s_ef, s_mf, s_busy, s_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (M_RegWrite && rs == M_Rd) return 2'b10;
    if (W_RegWrite && rs == W_Rd) return 2'b01;
    return 2'b00;
  endfunction

  // One clock: check all outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic exp_md, exp_lw;
    @(negedge clk);
    exp_md = rst_n && (stall_left > 0 || (!done_now && E_MdOp));
    exp_lw = E_ResultSrc_0 && (E_Rd != 0) && (D_Rs1 == E_Rd || D_Rs2 == E_Rd);
    s_fa = ForwardAE; s_fb = ForwardBE; s_fs = F_Stall; s_ds = D_Stall;
    s_es = E_Stall;   s_df = D_Flush;   s_ef = E_Flush; s_mf = M_Flush;
    s_busy = md_busy; s_done = md_done;
    check_eq("ForwardAE", s_fa, ref_fwd(E_Rs1));
    check_eq("ForwardBE", s_fb, ref_fwd(E_Rs2));
    check_eq("F_Stall",   s_fs, rst_n && (exp_lw || exp_md));
    check_eq("D_Stall",   s_ds, rst_n && (exp_lw || exp_md));
    check_eq("E_Stall",   s_es, exp_md);
    check_eq("M_Flush",   s_mf, exp_md);
    check_eq("md_busy",   s_busy, exp_md);
    check_eq("md_done",   s_done, rst_n && done_now);
    check_eq("E_Flush",   s_ef, rst_n && (exp_lw || E_PCSrc) && !exp_md);
    check_eq("D_Flush",   s_df, rst_n && E_PCSrc && !exp_md);
    @(posedge clk);
    if (!rst_n) begin
      stall_left = 0;
      done_now   = 1'b0;
    end else if (stall_left > 0) begin
      stall_left--;
      done_now = (stall_left == 0);
    end else if (done_now) begin
      done_now = 1'b0;
    end else if (E_MdOp) begin
      stall_left = (E_MdIsDiv ? DIV_LAT : MUL_LAT) - 1;
    end
    #1;
  endtask

  // Issue one M/D op (E_MdOp held high) and measure the stall run up to its done strobe.
  task automatic run_md(input bit div, input int lat, input string tag);
    int n;
    bit got_done;
    n = 0;
    got_done = 1'b0;
    E_MdOp = 1'b1;
    E_MdIsDiv = div;
    for (int k = 0; k < lat + 5; k++) begin
      step();
      if (k == 0) check_eq({tag, "_first_stall"}, s_busy, 1'b1);
      if (s_done) begin
        got_done = 1'b1;
        break;
      end
      if (s_es && s_mf) n++;
    end
    check_eq({tag, "_stall_len"}, n, lat);
    check_eq({tag, "_done_seen"}, got_done, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    {M_RegWrite, W_RegWrite, E_ResultSrc_0, E_PCSrc, E_MdOp, E_MdIsDiv} = '0;
    {D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd} = '0;
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Forwarding priority and x0 suppression.
    E_Rs1 = 5; M_Rd = 5; W_Rd = 5; M_RegWrite = 1'b1; W_RegWrite = 1'b1;
    step(); check_eq("fwd_mem_prio", s_fa, 2'b10);
    M_RegWrite = 1'b0;
    step(); check_eq("fwd_wb", s_fa, 2'b01);
    E_Rs1 = 0;
    step(); check_eq("fwd_x0", s_fa, 2'b00);
    W_RegWrite = 1'b0; M_Rd = 0; W_Rd = 0;

    // Load-use hazard, then the same load targeting x0.
    E_ResultSrc_0 = 1'b1; E_Rd = 7; D_Rs1 = 1; D_Rs2 = 7;
    step();
    check_eq("lw_fstall", s_fs, 1'b1);
    check_eq("lw_dstall", s_ds, 1'b1);
    check_eq("lw_eflush", s_ef, 1'b1);
    E_ResultSrc_0 = 1'b0;
    step(); check_eq("lw_released", s_fs, 1'b0);
    E_ResultSrc_0 = 1'b1; E_Rd = 0; D_Rs2 = 0;
    step(); check_eq("lw_x0_nostall", s_fs, 1'b0);
    E_ResultSrc_0 = 1'b0;

    // Single MUL, then idle.
    run_md(1'b0, MUL_LAT, "mul");
    E_MdOp = 1'b0;
    step(); check_eq("mul_idle_busy", s_busy, 1'b0);

    // Two DIVs back to back.
    run_md(1'b1, DIV_LAT, "div1");
    run_md(1'b1, DIV_LAT, "div2");
    E_MdOp = 1'b0;
    step(); check_eq("div_idle_busy", s_busy, 1'b0);

    // Branch while stalled must not flush; branch when idle must.
    E_MdOp = 1'b1; E_MdIsDiv = 1'b0; E_PCSrc = 1'b1;
    step();
    check_eq("br_md_eflush", s_ef, 1'b0);
    check_eq("br_md_dflush", s_df, 1'b0);
    E_PCSrc = 1'b0;
    for (int k = 0; k < MUL_LAT + 4 && !s_done; k++) step();
    check_eq("br_md_done_reached", s_done, 1'b1);
    E_MdOp = 1'b0; E_PCSrc = 1'b1;
    step();
    check_eq("br_idle_eflush", s_ef, 1'b1);
    check_eq("br_idle_dflush", s_df, 1'b1);
    E_PCSrc = 1'b0;

    // Reset in the middle of a DIV (counter at 10), then a fresh full-length op.
    E_MdOp = 1'b1; E_MdIsDiv = 1'b1;
    for (int k = 0; k < 23; k++) step();
    check_eq("rst_pre_busy", s_busy, 1'b1);
    rst_n = 1'b0;
    step(); check_eq("rst_low_stall", s_es, 1'b0);
    rst_n = 1'b1; E_MdOp = 1'b0;
    step();
    check_eq("rst_after_busy", s_busy, 1'b0);
    check_eq("rst_after_done", s_done, 1'b0);
    run_md(1'b1, DIV_LAT, "div_after_rst");
    E_MdOp = 1'b0;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 49) != 0);
      M_RegWrite    = $urandom_range(0, 1);
      W_RegWrite    = $urandom_range(0, 1);
      E_ResultSrc_0 = ($urandom_range(0, 2) == 0);
      E_PCSrc       = ($urandom_range(0, 3) == 0);
      E_MdOp        = ($urandom_range(0, 5) == 0);
      E_MdIsDiv     = ($urandom_range(0, 3) == 0);
      D_Rs1 = REG_AW'($urandom_range(0, 3));
      D_Rs2 = REG_AW'($urandom_range(0, 3));
      E_Rs1 = REG_AW'($urandom_range(0, 3));
      E_Rs2 = REG_AW'($urandom_range(0, 3));
      E_Rd  = REG_AW'($urandom_range(0, 3));
      M_Rd  = REG_AW'($urandom_range(0, 3));
      W_Rd  = REG_AW'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
